dcache_write_buffer: RTL
========================

DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- l1_address  in  16 (lc3b_word)  L1 dcache line address; bits [3:0] ignored.
- l1_read  in  1  L1 line-fill request; held until l1_resp.
- l1_write  in  1  L1 dirty-line write-back request; held until l1_resp.
- l1_wdata  in  128 (pmem_L1_bus)  write-back line.
- l1_rdata  out  128 (pmem_L1_bus)  fill line; valid while l1_resp=1.
- l1_resp  out  1  one-cycle completion pulse to L1.
- pmem_address  out  16 (lc3b_word)  line address to memory; bits [3:0] always 0.
- pmem_read  out  1  memory read request.
- pmem_write  out  1  memory write request.
- pmem_wdata  out  128 (pmem_L1_bus)  line to memory.
- pmem_rdata  in  128 (pmem_L1_bus)  line from memory.
- pmem_resp  in  1  memory completion; one-cycle pulse.
- buf_valid  out  1  buffer holds an undrained dirty line.
REQ-002 The block SHALL have no parameters; capacity is one 128-bit line plus its 12-bit tag (address[15:4]).

Function
REQ-003 States SHALL be EMPTY, FULL, READ, DRAIN, RESP; state and all outputs registered.
REQ-004 In EMPTY with l1_write=1: capture l1_wdata and l1_address[15:4], set buf_valid, go to RESP; l1_resp=1 the next cycle (1-cycle write latency, no memory access).
REQ-005 In FULL with l1_write=1: no capture; go to DRAIN; the new write is accepted only after the drain completes and the block returns to EMPTY.
REQ-006 In EMPTY or FULL with l1_read=1 and a buffer hit (buf_valid=1, tag equals l1_address[15:4]): l1_rdata=buffered line, go to RESP; no memory access.
REQ-007 In EMPTY or FULL with l1_read=1 and no hit: go to READ with pmem_read=1, pmem_address={l1_address[15:4],4'h0}; on pmem_resp, latch pmem_rdata into l1_rdata, go to RESP.
REQ-008 Priority in EMPTY/FULL: l1_read over l1_write over drain; l1_read and l1_write both high is illegal and SHALL be treated as l1_read.
REQ-009 In FULL with no L1 request: go to DRAIN.
REQ-010 In DRAIN: pmem_write=1, pmem_address={tag,4'h0}, pmem_wdata=buffered line, held constant until pmem_resp; on pmem_resp clear buf_valid, go to EMPTY. A drain SHALL NOT be aborted by L1 requests.
REQ-011 pmem_read and pmem_write SHALL never both be 1.
REQ-012 RESP SHALL last exactly one cycle with l1_resp=1, ignore all inputs, then go to FULL if buf_valid=1, else EMPTY.
REQ-013 Outside RESP, l1_resp=0; l1_rdata holds its last value.
REQ-014 A read hit SHALL return the buffered line, never stale memory data.

Reset
REQ-015 While reset_n=0: state=EMPTY, buf_valid=0, l1_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, l1_rdata=0, tag=0; outputs change without waiting for clk.
REQ-016 Reset during DRAIN or READ SHALL drop pmem_write/pmem_read immediately and discard the buffered line; memory must then ignore the aborted request.

Verification
REQ-017 Write to empty: l1_write, l1_address=16'h1234, l1_wdata=128'hA5..A5 -> l1_resp 1 cycle later, buf_valid=1; then pmem_write=1 with pmem_address=16'h1230 and that data; after pmem_resp, buf_valid=0.
REQ-018 Read hit: buffer holds 16'h1230 line; l1_read at 16'h123E before drain starts -> l1_resp next cycle, l1_rdata=buffered line, pmem_read stays 0.
REQ-019 Read miss while FULL: buffer 16'h1230, l1_read at 16'h4000 -> pmem_read=1 with pmem_address=16'h4000 (no pmem_write); after pmem_resp with 128'h55..55, l1_rdata=128'h55..55 with l1_resp; drain follows.
REQ-020 Write while draining: l1_write at 16'h2000 during DRAIN -> pmem_write stays high until pmem_resp; new line captured afterwards, l1_resp after first drain completes, second drain uses 16'h2000.
REQ-021 Reset mid-drain: reset_n=0 asynchronously while pmem_write=1 -> pmem_write=0 and buf_valid=0 before next clk edge; after release, block idle in EMPTY.
REQ-022 Exclusivity: random request stimulus over 10k cycles -> pmem_read&&pmem_write never true; l1_resp never high two consecutive cycles.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// One-line write buffer between the L1 dcache and physical memory.
// Ports: clk, reset_n (async, active-low); L1 side l1_address, l1_read,
// l1_write, l1_wdata, l1_rdata, l1_resp; memory side pmem_address,
// pmem_read, pmem_write, pmem_wdata, pmem_rdata, pmem_resp; buf_valid.
module dcache_write_buffer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  l1_address,
    input  logic         l1_read,
    input  logic         l1_write,
    input  logic [127:0] l1_wdata,
    output logic [127:0] l1_rdata,
    output logic         l1_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         buf_valid
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_FULL,
        S_READ,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [11:0]    tag_q, tag_d;
    logic [127:0]   line_q, line_d;
    logic           valid_q, valid_d;
    logic [127:0]   rdata_q, rdata_d;
    logic           resp_q, resp_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [15:0]    addr_q, addr_d;
    logic           hit;
    logic           idle;
    logic           unused_addr_lsb;

    // Line offset bits play no part in a line-granular buffer.
    assign unused_addr_lsb = ^l1_address[3:0];

    assign hit  = valid_q && (tag_q == l1_address[15:4]);
    assign idle = (state_q == S_EMPTY) || (state_q == S_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            tag_q   <= '0;
            line_q  <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
        end
    end

    // Read wins over write; in FULL a write simply forces the drain
    // and is picked up again once the buffer is EMPTY.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (l1_read)
                    state_d = hit ? S_RESP : S_READ;
                else if (l1_write)
                    state_d = S_RESP;
            end
            S_FULL: begin
                if (l1_read)
                    state_d = hit ? S_RESP : S_READ;
                else
                    state_d = S_DRAIN;
            end
            S_READ: begin
                if (pmem_resp)
                    state_d = S_RESP;
            end
            S_DRAIN: begin
                if (pmem_resp)
                    state_d = S_EMPTY;
            end
            S_RESP: begin
                state_d = valid_q ? S_FULL : S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        tag_d   = tag_q;
        line_d  = line_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        resp_d  = (state_d == S_RESP);
        rd_d    = (state_d == S_READ);
        wr_d    = (state_d == S_DRAIN);

        if (state_q == S_EMPTY && !l1_read && l1_write) begin
            line_d  = l1_wdata;
            tag_d   = l1_address[15:4];
            valid_d = 1'b1;
        end

        if (state_q == S_DRAIN && pmem_resp)
            valid_d = 1'b0;

        if (idle && l1_read && hit)
            rdata_d = line_q;

        if (state_q == S_READ && pmem_resp)
            rdata_d = pmem_rdata;

        // Address is loaded on entry and then held for the whole request.
        if (state_d == S_READ && state_q != S_READ)
            addr_d = {l1_address[15:4], 4'h0};
        else if (state_d == S_DRAIN && state_q != S_DRAIN)
            addr_d = {tag_q, 4'h0};
    end

    assign l1_rdata     = rdata_q;
    assign l1_resp      = resp_q;
    assign pmem_address = addr_q;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_wdata   = line_q;
    assign buf_valid    = valid_q;

endmodule
